// File: rtl/stalin_unpack.sv
// Streams a captured packed list of unsigned elements out over a valid/ready
// interface, one element per accepted transfer, flagging any descending step.
module stalin_unpack #(
    parameter int N     = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [N*WIDTH-1:0]       data_in,
    input  logic [$clog2(N+1)-1:0]   in_len,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [WIDTH-1:0]         m_data,
    output logic                     m_last,
    output logic                     busy,
    output logic                     done,
    output logic                     order_err
);
    localparam int LW = $clog2(N + 1);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [LW-1:0] N_L   = LW'(N);
    localparam logic [LW-1:0] ONE_L = LW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t               state_q,     state_d;
    logic [N*WIDTH-1:0]   list_q,      list_d;
    logic [LW-1:0]        len_q,       len_d;
    logic [LW-1:0]        idx_q,       idx_d;
    logic [WIDTH-1:0]     prev_q,      prev_d;
    logic                 m_valid_q,   m_valid_d;
    logic [WIDTH-1:0]     m_data_q,    m_data_d;
    logic                 m_last_q,    m_last_d;
    logic                 busy_q,      busy_d;
    logic                 done_q,      done_d;
    logic                 order_err_q, order_err_d;

    logic [WIDTH-1:0]     elems [N];
    logic [LW-1:0]        eff_len;
    logic [LW-1:0]        nxt_idx;
    logic [LW-1:0]        last_idx;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_elem
            assign elems[gi] = list_q[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign eff_len  = (in_len > N_L) ? N_L : in_len;
    assign nxt_idx  = idx_q + ONE_L;
    assign last_idx = len_q - ONE_L;

    always_comb begin
        state_d     = state_q;
        list_d      = list_q;
        len_d       = len_q;
        idx_d       = idx_q;
        prev_d      = prev_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_last_d    = m_last_q;
        busy_d      = busy_q;
        done_d      = done_q;
        order_err_d = order_err_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    list_d      = data_in;
                    len_d       = eff_len;
                    idx_d       = '0;
                    order_err_d = 1'b0;
                    if (eff_len != '0) begin
                        state_d   = STREAM;
                        m_valid_d = 1'b1;
                        m_data_d  = data_in[WIDTH-1:0];
                        m_last_d  = (eff_len == ONE_L);
                        busy_d    = 1'b1;
                        done_d    = 1'b0;
                    end else begin
                        // Empty list goes straight to DONE without a beat.
                        state_d   = DONE;
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (m_valid_q && m_ready) begin
                    prev_d = m_data_q;
                    if ((idx_q != '0) && (m_data_q < prev_q)) begin
                        order_err_d = 1'b1;
                    end
                    if (idx_q == last_idx) begin
                        state_d   = DONE;
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        idx_d    = nxt_idx;
                        m_data_d = elems[nxt_idx[IW-1:0]];
                        m_last_d = (nxt_idx == last_idx);
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                m_valid_d = 1'b0;
                m_last_d  = 1'b0;
                busy_d    = 1'b0;
                done_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            list_q      <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            prev_q      <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            order_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            list_q      <= list_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            prev_q      <= prev_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_last_q    <= m_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            order_err_q <= order_err_d;
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_last    = m_last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign order_err = order_err_q;

endmodule

// File: tb/tb_stalin_unpack.sv
// Directed bench for stalin_unpack with N=4, WIDTH=8; inputs driven and
// outputs sampled on the falling edge.
module tb_stalin_unpack;
    localparam int N     = 4;
    localparam int WIDTH = 8;
    localparam int LW    = $clog2(N + 1);

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [N*WIDTH-1:0] data_in = '0;
    logic [LW-1:0]      in_len = '0;
    logic               m_valid;
    logic               m_ready = 1'b0;
    logic [WIDTH-1:0]   m_data;
    logic               m_last;
    logic               busy;
    logic               done;
    logic               order_err;

    int checks = 0;
    int errors = 0;

    stalin_unpack #(.N(N), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .data_in   (data_in),
        .in_len    (in_len),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done),
        .order_err (order_err)
    );

    always #5 clk = ~clk;

    // Pulse start for one edge; returns at the falling edge after capture.
    task automatic pulse_start(input logic [N*WIDTH-1:0] d, input logic [LW-1:0] l);
        @(negedge clk);
        data_in = d;
        in_len  = l;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({m_valid, m_last, m_data, busy, done, order_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b l=%b d=%h b=%b dn=%b oe=%b, want all 0",
                     m_valid, m_last, m_data, busy, done, order_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_stream;
        logic [WIDTH-1:0] exp_d [4] = '{8'h02, 8'h05, 8'h07, 8'h09};
        m_ready = 1'b1;
        pulse_start(32'h09070502, 3'd4);
        for (int i = 0; i < 4; i++) begin
            $display("stream beat %0d: valid=%b data=%h last=%b", i, m_valid, m_data, m_last);
            checks++;
            if (m_valid !== 1'b1 || m_data !== exp_d[i] || m_last !== (i == 3) || busy !== 1'b1) begin
                errors++;
                $display("FAIL stream_beat%0d: got v=%b d=%h l=%b b=%b, want v=1 d=%h l=%b b=1",
                         i, m_valid, m_data, m_last, busy, exp_d[i], (i == 3));
            end
            @(negedge clk);
        end
        checks++;
        if (m_valid !== 1'b0 || m_last !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || order_err !== 1'b0) begin
            errors++;
            $display("FAIL stream_done: got v=%b l=%b dn=%b b=%b oe=%b, want v=0 l=0 dn=1 b=0 oe=0",
                     m_valid, m_last, done, busy, order_err);
        end
    endtask

    task automatic test_backpressure;
        logic [WIDTH-1:0] exp_d [4] = '{8'h02, 8'h05, 8'h07, 8'h09};
        int               got = 0;
        logic             held = 1'b0;
        logic [WIDTH-1:0] held_d = '0;
        m_ready = 1'b1;
        pulse_start(32'h09070502, 3'd4);
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            if (held) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== held_d) begin
                    errors++;
                    $display("FAIL bp_hold: got v=%b d=%h, want v=1 d=%h", m_valid, m_data, held_d);
                end
            end
            m_ready = cyc[0];
            held = 1'b0;
            if (m_valid) begin
                if (m_ready) begin
                    $display("bp beat %0d: data=%h", got, m_data);
                    checks++;
                    if (got >= 4 || m_data !== exp_d[got & 3]) begin
                        errors++;
                        $display("FAIL bp_beat%0d: got %h, want %h", got, m_data, exp_d[got & 3]);
                    end
                    got++;
                end else begin
                    held   = 1'b1;
                    held_d = m_data;
                end
            end
            @(negedge clk);
        end
        checks++;
        if (got !== 4 || done !== 1'b1) begin
            errors++;
            $display("FAIL bp_count: got %0d beats done=%b, want 4 beats done=1", got, done);
        end
        m_ready = 1'b1;
    endtask

    task automatic test_empty_and_clamp;
        int seen = 0;
        int got  = 0;
        logic last_ok = 1'b0;
        logic [WIDTH-1:0] exp_d [4] = '{8'h02, 8'h05, 8'h07, 8'h09};
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start(32'h09070502, 3'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL empty_done: got dn=%b b=%b, want dn=1 b=0", done, busy);
        end
        for (int i = 0; i < 4; i++) begin
            if (m_valid) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL empty_valid: got %0d valid cycles, want 0", seen);
        end
        pulse_start(32'h09070502, 3'd7);
        for (int cyc = 0; cyc < 12 && !done; cyc++) begin
            if (m_valid) begin
                $display("clamp beat %0d: data=%h last=%b", got, m_data, m_last);
                checks++;
                if (got >= 4 || m_data !== exp_d[got & 3]) begin
                    errors++;
                    $display("FAIL clamp_beat%0d: got %h, want %h", got, m_data, exp_d[got & 3]);
                end
                if (m_last) last_ok = (got == 3);
                got++;
            end
            @(negedge clk);
        end
        checks++;
        if (got !== 4 || last_ok !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL clamp_count: got %0d beats last_ok=%b done=%b, want 4 1 1", got, last_ok, done);
        end
    endtask

    task automatic test_order;
        logic exp_oe [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        m_ready = 1'b1;
        pulse_start(32'h08010303, 3'd4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (order_err !== exp_oe[i]) begin
                errors++;
                $display("FAIL order_beat%0d: got oe=%b, want %b", i, order_err, exp_oe[i]);
            end
            @(negedge clk);
        end
        checks++;
        if (order_err !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL order_sticky: got oe=%b dn=%b, want oe=1 dn=1", order_err, done);
        end
        @(negedge clk);
        checks++;
        if (order_err !== 1'b1) begin
            errors++;
            $display("FAIL order_hold: got oe=%b, want 1", order_err);
        end
        pulse_start(32'h09070502, 3'd4);
        checks++;
        if (order_err !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL order_clear: got oe=%b dn=%b, want oe=0 dn=0", order_err, done);
        end
        for (int i = 0; i < 5; i++) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [WIDTH-1:0] exp_d [4] = '{8'h02, 8'h05, 8'h07, 8'h09};
        m_ready = 1'b1;
        pulse_start(32'h09070502, 3'd4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== exp_d[i]) begin
                errors++;
                $display("FAIL ignore_start_beat%0d: got v=%b d=%h, want v=1 d=%h", i, m_valid, m_data, exp_d[i]);
            end
            start   = (i == 1);
            data_in = 32'hFFEEDDCC;
            in_len  = 3'd2;
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start_done: got dn=%b v=%b, want dn=1 v=0", done, m_valid);
        end
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        m_ready = 1'b1;
        pulse_start(32'h09070502, 3'd4);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({m_valid, m_last, m_data, busy, done, order_err} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got v=%b l=%b d=%h b=%b dn=%b oe=%b, want all 0",
                     m_valid, m_last, m_data, busy, done, order_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (m_valid || busy || done) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL midreset_quiet: got %0d active cycles, want 0", seen);
        end
        pulse_start(32'h09070502, 3'd4);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h02) begin
            errors++;
            $display("FAIL midreset_restart: got v=%b d=%h, want v=1 d=02", m_valid, m_data);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_empty_and_clamp();
        test_order();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
